// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver.
// Watches the debounced PS/2 clock for falling edges. On each one it captures the
// debounced data line and assembles an 11-bit frame: start, 8 data bits LSB first,
// odd parity, stop. Each completed frame produces exactly one status pulse.
//
// Output handshake: rx_valid, rx_parity_err and rx_frame_err are one-cycle strobes
// with no back-pressure. At most one of them is high in any cycle. rx_data is
// updated only in the cycle rx_valid is high, and it holds its value until the
// next good frame. A byte that is not taken before the next rx_valid is overwritten.
module ps2_receiver #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]    state;
    logic          prev_clk;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          fall;

    // A falling PS/2 clock edge is the only moment the data line is meaningful.
    assign fall      = prev_clk & ~ps2_clk;
    assign state_dbg = state;

    // Frame state machine, shift register, timeout counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            prev_clk      <= 1'b0;
            bit_cnt       <= 3'd0;
            shreg         <= 8'h00;
            parity_bit    <= 1'b0;
            to_cnt        <= '0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            prev_clk      <= ps2_clk;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            if (state == S_IDLE) begin
                // The counter stays at 0 in IDLE. A fall with data high is line
                // noise or a released line, and it is ignored.
                to_cnt <= '0;
                if (fall && !ps2_data) begin
                    state   <= S_DATA;
                    bit_cnt <= 3'd0;
                    busy    <= 1'b1;
                end
            end else if (fall) begin
                // A fall in the same cycle as a timeout wins, so the frame continues.
                to_cnt <= '0;
                case (state)
                    S_DATA: begin
                        shreg   <= {ps2_data, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        parity_bit <= ps2_data;
                        state      <= S_STOP;
                    end
                    default: begin
                        // Stop bit. A bad stop bit is reported as a framing error
                        // whatever the parity was.
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (!ps2_data) begin
                            rx_frame_err <= 1'b1;
                        end else if (^{shreg, parity_bit}) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_parity_err <= 1'b1;
                        end
                    end
                endcase
            end else if (to_cnt == TO_LAST) begin
                // The device stopped clocking mid-frame: drop the partial frame.
                state        <= S_IDLE;
                busy         <= 1'b0;
                rx_frame_err <= 1'b1;
                to_cnt       <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver. It covers directed frames from the test plan plus
// randomized frames. The expected status events go into a queue, and a monitor
// compares each pulse the DUT emits against it.
module tb_ps2_receiver;

    localparam int TO = 200;
    localparam int W  = 10;  // {kind[1:0], data[7:0]}
    localparam logic [1:0] K_VALID  = 2'd1;
    localparam logic [1:0] K_PARITY = 2'd2;
    localparam logic [1:0] K_FRAME  = 2'd3;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       busy;
    logic [1:0] state_dbg;

    logic [W-1:0] exp_q[$];
    logic [7:0]   held;
    int           tests;
    int           failed;
    logic         prev_pulse;

    ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: total ones over data+parity odd means good parity.
    function automatic logic [W-1:0] model(input logic [7:0] d, input logic p, input logic s);
        int ones;
        ones = $countones(d) + (p ? 1 : 0);
        if (s == 1'b0) return {K_FRAME, 8'h00};
        if (ones % 2 == 1) return {K_VALID, d};
        return {K_PARITY, 8'h00};
    endfunction

    // One PS/2 bit: data set up while clock high, 20-cycle low, 10-cycle high.
    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        exp_q.push_back(model(d, p, s));
        send_bit(1'b0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    // monitor / scoreboard
    always @(posedge clk) begin
        int pulses;
        logic [1:0] kind;
        logic [W-1:0] e;
        #1;
        if (reset) begin
            prev_pulse = 1'b0;
        end else begin
            pulses = int'(rx_valid) + int'(rx_parity_err) + int'(rx_frame_err);
            if (pulses > 0) begin
                check("pulse_exclusive", pulses, 1);
                check("pulse_width", {31'd0, prev_pulse}, 32'd0);
                check("busy_at_end", {31'd0, busy}, 32'd0);
                kind = rx_valid ? K_VALID : (rx_parity_err ? K_PARITY : K_FRAME);
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_pulse: kind %0d with no expected event at %0t", kind, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {30'd0, kind}, {30'd0, e[9:8]});
                    if (e[9:8] == K_VALID) held = e[7:0];
                    check("rx_data", {24'd0, rx_data}, {24'd0, held});
                end
            end
            prev_pulse = (pulses > 0);
        end
    end

    // stimulus
    initial begin
        logic [7:0] d;
        logic p, s;
        int r;
        tests = 0;
        failed = 0;
        held = 8'h00;
        prev_pulse = 1'b0;
        reset = 1'b1;
        ps2_clk = 1'b0;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_flags", {28'd0, rx_valid, rx_parity_err, rx_frame_err, busy}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        check("idle_after_rise", {31'd0, busy}, 32'd0);

        // good frame, parity error, framing error
        send_frame(8'h1C, 1'b0, 1'b1);
        check("busy_after_frame", {31'd0, busy}, 32'd0);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b0);

        // timeout after start plus 4 data bits
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        exp_q.push_back({K_FRAME, 8'h00});
        repeat (TO - 30) @(negedge clk);
        check("timeout_not_yet", {30'd0, rx_frame_err, busy}, 32'd1);
        @(negedge clk);
        check("timeout_fires", {30'd0, rx_frame_err, busy}, 32'd2);
        repeat (20) @(negedge clk);
        send_frame(8'hF0, 1'b1, 1'b1);

        // back-to-back with minimum gap
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);

        // reset after 6 bits of a frame
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge clk);
        ps2_clk = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        check("midreset_flags", {28'd0, rx_valid, rx_parity_err, rx_frame_err, busy}, 32'd0);
        check("midreset_state", {30'd0, state_dbg}, 32'd0);
        held = 8'h00;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        check("no_false_start", {31'd0, busy}, 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);

        // randomized frames, mostly good, some parity/framing faults
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            p = ~(^d);
            if (r == 0) p = ~p;
            s = (r == 1) ? 1'b0 : 1'b1;
            repeat ($urandom_range(0, 30)) @(negedge clk);
            send_frame(d, p, s);
        end

        repeat (50) @(negedge clk);
        check("events_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // global time limit
    initial begin
        #2000000;
        $display("FAIL timeout_global: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Frame-level receiver for a PS/2 keyboard link. It sits directly downstream of the two debounce stages, one on PS/2 clock and one on PS/2 data. It detects falling edges of the debounced PS/2 clock and assembles 11-bit device-to-host frames: start, 8 data bits LSB first, odd parity, stop. It presents each good byte with a one-cycle strobe and flags parity, framing and timeout errors to the scan-code decoder.

## Interface
- TIMEOUT_CYCLES, default 200000: system clocks without a PS/2 falling edge, while mid-frame, before the frame is abandoned (2 ms at 100 MHz).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  debounced PS/2 clock, synchronous to clk.
- ps2_data  in  1  debounced PS/2 data, synchronous to clk.
- rx_data  out  8  last correctly received byte; held until the next good frame.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- rx_parity_err  out  1  one-cycle pulse; frame had a good stop bit but bad parity.
- rx_frame_err  out  1  one-cycle pulse; bad stop bit or timeout.
- busy  out  1  high while a frame is in progress (state is not IDLE).

## Operation
- Edge detect: prev_clk is a register holding ps2_clk from the previous cycle. fall = prev_clk & ~ps2_clk.
  - prev_clk resets to 0. The upstream debouncer output starts at 0 and rises as the line settles, so no false fall is seen after reset.
- ps2_data is sampled only in the cycle where fall is true.
- States:
  - IDLE:
    - fall with data=0 → DATA; bit_cnt=0; timeout counter cleared.
    - fall with data=1 → stay in IDLE, silently ignored.
  - DATA:
    - Each fall shifts data into shreg[7] with a right shift, giving LSB-first order. bit_cnt increments.
    - The fall that captures the 8th bit (bit_cnt=7) → PARITY.
  - PARITY: fall stores the parity bit → STOP.
  - STOP, on fall:
    - data=1 and (^shreg ^ parity)=1: rx_data<=shreg, rx_valid pulse.
    - data=1 and parity bad: rx_parity_err pulse, rx_data unchanged.
    - data=0: rx_frame_err pulse only. Framing takes precedence over parity.
    - Every case returns to IDLE.
- Timeout:
  - The counter, width $clog2(TIMEOUT_CYCLES)+1, runs in every non-IDLE state. It clears on every fall and holds at 0 in IDLE.
  - If it reaches TIMEOUT_CYCLES-1 with no fall in that cycle: → IDLE, rx_frame_err pulse, partial data discarded.
  - A fall in the same cycle wins; the frame continues.
- Status pulses are mutually exclusive and never last longer than one cycle.
- No flow control. A byte not consumed before the next rx_valid is overwritten.

## Timing
- Reset values: rx_data=0x00, rx_valid=0, rx_parity_err=0, rx_frame_err=0, busy=0, state=IDLE, prev_clk=0, counters=0.
- Reset is asynchronous and takes effect mid-frame immediately. The partial frame is lost and no pulse is generated.
- All outputs are registered.
- Latency: rx_valid, rx_parity_err or rx_frame_err rises on the clk edge at which the stop-bit fall is sampled, and falls on the next edge.
- busy rises on the edge sampling the start-bit fall. It falls on the same edge as the terminating pulse.
- A start bit may arrive on the cycle immediately after the stop-bit fall. Back-to-back frames need no idle gap beyond PS/2 line timing.
- Assumed input rates: the PS/2 clock is 10–16.7 kHz and each level lasts ≥20 clk cycles. At most one fall occurs per PS/2 clock period.

## Test plan
- Valid frame 0x1C: bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1 → rx_data=0x1C, rx_valid high exactly one cycle, no error pulses, busy low afterwards.
- Parity error: 0x1C sent with parity 1, stop 1 → rx_parity_err one cycle, rx_valid never high, rx_data keeps its prior value.
- Framing error: 0xF0 with parity 1, stop 0 → rx_frame_err one cycle only, no rx_parity_err, no rx_valid.
- Timeout: start plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES clocks → rx_frame_err one cycle, busy=0. A following full 0xF0 frame → rx_data=0xF0, rx_valid.
- Back-to-back frames 0xE0 (parity 0) then 0x75 (parity 0) with minimum gap → two rx_valid pulses carrying 0xE0 then 0x75.
- Reset asserted after 6 bits of a frame → outputs at reset values immediately, no pulses. After release, a 0x1C frame is received correctly and no false start comes from ps2_clk rising 0→1.
